// File: rtl/timer_pkg.sv
// Shared types and constants for the keypad-side timer entry loader.
package timer_pkg;

    typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} entry_state_t;

    localparam int BCD_W            = 4;
    localparam int MAX_SEC_TENS_DEF = 5;
    localparam int NDIGITS          = 3;

    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return d <= BCD_W'(9);
    endfunction

endpackage

// File: rtl/timer_entry_loader_if.sv
// Keypad strobes in, timer counter load buses and status out.
interface timer_entry_loader_if;
    import timer_pkg::*;

    logic             key_valid;
    logic [BCD_W-1:0] key_digit;
    logic             key_start;
    logic             key_cancel;
    logic             timer_zero;
    logic [BCD_W-1:0] min_data;
    logic [BCD_W-1:0] tens_data;
    logic [BCD_W-1:0] units_data;
    logic             loadn;
    logic             running;
    logic             err;
    logic [1:0]       ndigits;

    modport master (
        output key_valid, key_digit, key_start, key_cancel, timer_zero,
        input  min_data, tens_data, units_data, loadn, running, err, ndigits
    );

    modport slave (
        input  key_valid, key_digit, key_start, key_cancel, timer_zero,
        output min_data, tens_data, units_data, loadn, running, err, ndigits
    );

endinterface

// File: rtl/bcd_shift3.sv
// Three-digit BCD entry register; new digits enter at the units end.
module bcd_shift3
    import timer_pkg::*;
(
    input  logic             clock,
    input  logic             clr,
    input  logic             clear,
    input  logic             shift,
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dmin,
    output logic [BCD_W-1:0] dtens,
    output logic [BCD_W-1:0] dunits
);

    always_ff @(posedge clock) begin
        if (clr || clear) begin
            dmin   <= '0;
            dtens  <= '0;
            dunits <= '0;
        end else if (shift) begin
            dmin   <= dtens;
            dtens  <= dunits;
            dunits <= din;
        end
    end

endmodule

// File: rtl/timer_entry_loader.sv
// Entry FSM: collects digits, validates the start key, strobes loadn once
// and tracks the running timer until it reaches zero or is cancelled.
module timer_entry_loader
    import timer_pkg::*;
#(
    parameter int MAX_SEC_TENS = MAX_SEC_TENS_DEF
) (
    input logic                 clock,
    input logic                 clr,
    timer_entry_loader_if.slave bus
);

    entry_state_t     state_q, state_d;
    logic             phase_q, phase_d;
    logic             loadn_q, loadn_d;
    logic             running_q, running_d;
    logic             err_q, err_d;
    logic [1:0]       nd_q, nd_d;
    logic             shift, clear;
    logic             start_ok;
    logic [BCD_W-1:0] dmin, dtens, dunits;

    bcd_shift3 u_digits (
        .clock  (clock),
        .clr    (clr),
        .clear  (clear),
        .shift  (shift),
        .din    (bus.key_digit),
        .dmin   (dmin),
        .dtens  (dtens),
        .dunits (dunits)
    );

    assign start_ok = (dtens <= BCD_W'(MAX_SEC_TENS)) &&
                      ((dmin | dtens | dunits) != '0);

    // LOAD spans two cycles: the first arms loadn, the second releases it and
    // raises running, so timer_zero from the settling counters is never seen.
    always_comb begin
        state_d   = state_q;
        phase_d   = 1'b0;
        loadn_d   = 1'b1;
        running_d = 1'b0;
        err_d     = 1'b0;
        nd_d      = nd_q;
        shift     = 1'b0;
        clear     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.key_valid && !bus.key_cancel) begin
                    if (is_bcd(bus.key_digit)) begin
                        shift   = 1'b1;
                        nd_d    = 2'd1;
                        state_d = ENTRY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ENTRY: begin
                if (bus.key_cancel) begin
                    clear   = 1'b1;
                    nd_d    = 2'd0;
                    state_d = IDLE;
                end else if (bus.key_start) begin
                    if (start_ok) begin
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.key_valid) begin
                    if (is_bcd(bus.key_digit)) begin
                        shift = 1'b1;
                        nd_d  = (nd_q == 2'(NDIGITS)) ? nd_q : nd_q + 2'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (!phase_q) begin
                    loadn_d = 1'b0;
                    phase_d = 1'b1;
                end else begin
                    running_d = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (bus.key_cancel || bus.timer_zero) begin
                    clear   = 1'b1;
                    nd_d    = 2'd0;
                    state_d = IDLE;
                end else begin
                    running_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            state_q   <= IDLE;
            phase_q   <= 1'b0;
            loadn_q   <= 1'b1;
            running_q <= 1'b0;
            err_q     <= 1'b0;
            nd_q      <= 2'd0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            loadn_q   <= loadn_d;
            running_q <= running_d;
            err_q     <= err_d;
            nd_q      <= nd_d;
        end
    end

    assign bus.min_data   = dmin;
    assign bus.tens_data  = dtens;
    assign bus.units_data = dunits;
    assign bus.loadn      = loadn_q;
    assign bus.running    = running_q;
    assign bus.err        = err_q;
    assign bus.ndigits    = nd_q;

endmodule

// File: tb/tb_timer_entry_loader.sv
// Bench for timer_entry_loader: directed scenarios with literal expectations
// followed by random keypad traffic checked against a behavioural model.
module tb_timer_entry_loader;

    localparam int MAX_TENS = 5;

    logic clock = 1'b0;
    logic clr   = 1'b1;
    int   checks = 0;
    int   errors = 0;

    timer_entry_loader_if tif();

    timer_entry_loader #(.MAX_SEC_TENS(MAX_TENS)) dut (
        .clock (clock),
        .clr   (clr),
        .bus   (tif)
    );

    always #5 clock = ~clock;

    // Behavioural model: digits as a little list, load sequence as a countdown.
    int m_dig[3];
    int m_nd       = 0;
    int m_loadleft = 0;
    int m_run      = 0;
    int m_err      = 0;
    int m_loadn    = 1;
    bit m_on       = 1'b0;

    task automatic modelClear();
        for (int i = 0; i < 3; i++) m_dig[i] = 0;
        m_nd = 0;
    endtask

    task automatic modelStep();
        int d;
        d     = int'(tif.key_digit);
        m_err = 0;
        if (clr) begin
            modelClear();
            m_loadleft = 0;
            m_run      = 0;
            m_loadn    = 1;
            m_on       = 1'b1;
        end else if (m_loadleft == 2) begin
            m_loadleft = 1;
            m_loadn    = 0;
        end else if (m_loadleft == 1) begin
            m_loadleft = 0;
            m_loadn    = 1;
            m_run      = 1;
        end else if (m_run != 0) begin
            if (tif.key_cancel || tif.timer_zero) begin
                modelClear();
                m_run = 0;
            end
        end else begin
            if (tif.key_cancel) begin
                modelClear();
            end else if (tif.key_start && m_nd > 0) begin
                if (m_dig[1] > MAX_TENS || (m_dig[0] + m_dig[1] + m_dig[2]) == 0)
                    m_err = 1;
                else
                    m_loadleft = 2;
            end else if (tif.key_valid) begin
                if (d > 9) begin
                    m_err = 1;
                end else begin
                    m_dig[0] = m_dig[1];
                    m_dig[1] = m_dig[2];
                    m_dig[2] = d;
                    m_nd     = (m_nd < 3) ? m_nd + 1 : 3;
                end
            end
        end
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input int exp);
        checks++;
        if (act !== 8'(exp)) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        if (m_on) begin
            cmp("model.min_data",   8'(tif.min_data),   m_dig[0]);
            cmp("model.tens_data",  8'(tif.tens_data),  m_dig[1]);
            cmp("model.units_data", 8'(tif.units_data), m_dig[2]);
            cmp("model.ndigits",    8'(tif.ndigits),    m_nd);
            cmp("model.loadn",      8'(tif.loadn),      m_loadn);
            cmp("model.running",    8'(tif.running),    m_run);
            cmp("model.err",        8'(tif.err),        m_err);
        end
    endtask

    task automatic applyStimulus(input bit v, input int d, input bit s,
                                 input bit c, input bit z, input bit r);
        tif.key_valid  = v;
        tif.key_digit  = 4'(d);
        tif.key_start  = s;
        tif.key_cancel = c;
        tif.timer_zero = z;
        clr            = r;
        @(posedge clock);
        modelStep();
        @(negedge clock);
        checkOutput();
    endtask

    task automatic key(input int d);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit z);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, z, 1'b0);
    endtask

    task automatic cancel();
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic start(input bit z);
        applyStimulus(1'b0, 0, 1'b1, 1'b0, z, 1'b0);
    endtask

    task automatic expectDigits(input string tag, input int a, input int b, input int c);
        cmp({tag, ".min"},   8'(tif.min_data),   a);
        cmp({tag, ".tens"},  8'(tif.tens_data),  b);
        cmp({tag, ".units"}, 8'(tif.units_data), c);
    endtask

    initial begin
        int r, d;
        bit v, s, c, z, rs;

        tif.key_valid  = 1'b0;
        tif.key_digit  = '0;
        tif.key_start  = 1'b0;
        tif.key_cancel = 1'b0;
        tif.timer_zero = 1'b0;

        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        expectDigits("reset", 0, 0, 0);
        cmp("reset.loadn",   8'(tif.loadn),   1);
        cmp("reset.running", 8'(tif.running), 0);
        cmp("reset.err",     8'(tif.err),     0);
        cmp("reset.ndigits", 8'(tif.ndigits), 0);

        key(1); key(3); key(0);
        expectDigits("entry130", 1, 3, 0);
        cmp("entry130.ndigits", 8'(tif.ndigits), 3);
        cmp("entry130.loadn",   8'(tif.loadn),   1);
        cmp("entry130.err",     8'(tif.err),     0);

        cancel();
        key(1); key(2); key(3); key(4);
        expectDigits("shiftout", 2, 3, 4);
        cmp("shiftout.ndigits", 8'(tif.ndigits), 3);

        cancel();
        key(1); key(7); key(0);
        start(1'b0);
        cmp("reject170.err",   8'(tif.err),   1);
        cmp("reject170.loadn", 8'(tif.loadn), 1);
        idle(1'b0);
        cmp("reject170.err_end", 8'(tif.err),   0);
        cmp("reject170.loadn2",  8'(tif.loadn), 1);
        expectDigits("reject170", 1, 7, 0);

        cancel();
        key(2); key(5); key(9);
        start(1'b1);
        cmp("accept.loadn_n",   8'(tif.loadn),   1);
        idle(1'b1);
        cmp("accept.loadn_n1",  8'(tif.loadn),   0);
        cmp("accept.run_n1",    8'(tif.running), 0);
        idle(1'b1);
        cmp("accept.loadn_n2",  8'(tif.loadn),   1);
        cmp("accept.run_n2",    8'(tif.running), 1);
        idle(1'b0);
        idle(1'b0);
        cmp("accept.run_n4",    8'(tif.running), 1);
        expectDigits("accept", 2, 5, 9);
        idle(1'b1);
        cmp("accept.run_n5",    8'(tif.running), 0);
        expectDigits("accept_end", 0, 0, 0);

        key(1); key(2);
        applyStimulus(1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        expectDigits("startdigit", 0, 1, 2);
        cmp("startdigit.err", 8'(tif.err), 0);
        idle(1'b0); idle(1'b0);
        cmp("startdigit.run", 8'(tif.running), 1);
        cancel();
        cmp("cancelrun.running", 8'(tif.running), 0);
        cmp("cancelrun.ndigits", 8'(tif.ndigits), 0);

        key(0); key(0); key(12);
        cmp("illegal.err",     8'(tif.err),     1);
        cmp("illegal.ndigits", 8'(tif.ndigits), 2);
        start(1'b0);
        cmp("zerostart.err",   8'(tif.err),   1);
        idle(1'b0);
        cmp("zerostart.loadn", 8'(tif.loadn), 1);
        idle(1'b0);
        cmp("zerostart.loadn2", 8'(tif.loadn),  1);
        cmp("zerostart.run",    8'(tif.running), 0);

        cancel();
        key(0); key(4); key(5);
        start(1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("clrload.loadn",   8'(tif.loadn),   1);
        cmp("clrload.running", 8'(tif.running), 0);
        expectDigits("clrload", 0, 0, 0);
        idle(1'b0);
        cmp("clrload.loadn2",  8'(tif.loadn),   1);

        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 99);
            d  = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            z  = ($urandom_range(0, 9) < 2);
            rs = (r < 1);
            v  = (r >= 1 && r < 40) || (r >= 60 && r < 66);
            s  = (r >= 40 && r < 55) || (r >= 60 && r < 66);
            c  = (r >= 55 && r < 60);
            applyStimulus(v, d, s, c, z, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_entry_loader.md
# timer_entry_loader

Keypad-side writer for the minutes/seconds timer. It collects BCD digits typed by the user into a three-digit entry register (minute units, second tens, second units) and validates the entry on a start key. It then drives the parallel `data` buses and the active-low `loadn` strobe consumed by the timer's digit counters. It holds the timer in a running state until the counter chain reports zero or the user cancels.

## Interface
- `MAX_SEC_TENS`, default 5: largest legal second-tens digit; higher values are rejected at start.
- `clock`  in  1  sole clock; all state changes on rising edge
- `clr`  in  1  reset, synchronous, active-high
- `key_valid`  in  1  one-cycle strobe: `key_digit` holds a new key
- `key_digit`  in  4  BCD digit 0–9; codes 10–15 are illegal
- `key_start`  in  1  one-cycle strobe: start request
- `key_cancel`  in  1  one-cycle strobe: abort entry or run
- `timer_zero`  in  1  high when all timer counters read 0
- `min_data`  out  4  minute-units digit to minutes counter `data`
- `tens_data`  out  4  second-tens digit to MOD6 counter `data`
- `units_data`  out  4  second-units digit to MOD10 counter `data`
- `loadn`  out  1  active-low load strobe, low for exactly one cycle per accepted start
- `running`  out  1  high while the timer is counting
- `err`  out  1  one-cycle pulse on a rejected key or a rejected start
- `ndigits`  out  2  digits entered so far, saturating at 3

## Operation
- States: IDLE, ENTRY, LOAD, RUN.
- **IDLE**
  - Digit register is 0 and `ndigits`=0.
  - A legal `key_valid` shifts the digit in and moves to ENTRY.
  - `key_start` or `key_cancel` is ignored.
- **Digit shift** (IDLE or ENTRY)
  - `min_data` ← `tens_data`, `tens_data` ← `units_data`, `units_data` ← `key_digit`.
  - The old `min_data` is discarded; `ndigits` saturates at 3.
- **Illegal digit** (`key_digit` > 9)
  - No shift; `err` pulses.
- **ENTRY**
  - Rejected start: `key_start` with `tens_data` > `MAX_SEC_TENS`, or with all three digits 0. Response: `err` pulses, stay in ENTRY, digits unchanged.
  - Accepted start: go to LOAD.
  - `key_cancel`: clear digits and `ndigits`, go to IDLE.
- **LOAD**
  - Lasts one cycle with `loadn`=0 and the data buses stable.
  - Unconditionally goes to RUN; all keys are ignored.
- **RUN**
  - `running`=1. The data buses hold the loaded value; `key_valid` and `key_start` are ignored.
  - `key_cancel` or `timer_zero` → IDLE with digits cleared.
  - `timer_zero` is ignored in the first RUN cycle, because the counters are still settling after the load.
- **Priority within one cycle:** `clr` > `key_cancel` > `key_start` > `key_valid`.
  - Simultaneous start and digit in ENTRY: start is evaluated on the current digits and the digit is dropped, with no `err`.

## Timing
- **Reset values:** state IDLE, all data buses 0, `loadn`=1, `running`=0, `err`=0, `ndigits`=0.
- **Digit path:** `key_valid` sampled at edge N → new digits and `ndigits` visible after edge N.
- **Accepted start:** `key_start` at edge N → `loadn`=0 during cycle N+1 → `loadn`=1 and `running`=1 from edge N+2.
- **Early end of RUN:** the earliest `timer_zero` honoured is at edge N+3 → IDLE, `running`=0 after that edge.
- **`err`:** asserted for the single cycle following the offending edge.
- **Reset mid-operation:**
  - `clr` in LOAD forces `loadn`=1 after the same edge; no second strobe is issued.
  - `clr` in RUN drops `running` after the edge.
- **Glitch-free outputs:** all outputs are registered, because `loadn` feeds a negedge-sensitive load.

## Structure
- **Shared package `timer_pkg`:**
  - state enum `entry_state_t` {IDLE, ENTRY, LOAD, RUN}
  - `BCD_W`=4
  - `MAX_SEC_TENS_DEF`=5
  - `NDIGITS`=3
- **Sub-module `bcd_shift3`:** three 4-bit registers with synchronous clear, shift-enable and serial digit input; exposes the three digits.
- **Top module:** holds the FSM, validation, the `loadn`/`err` registers and the `ndigits` counter.

## Test plan
- **Digit entry:** reset, then keys 1,3,0 → digits 1/3/0, `ndigits`=3, `loadn`=1, `err`=0.
- **Shift-out:** keys 1,2,3,4 → digits 2/3/4 (1 discarded), `ndigits`=3.
- **Rejected start:** enter 1,7,0 then start → `err` pulse of 1 cycle, state ENTRY, `loadn` never low, digits 1/7/0.
- **Accepted start:** enter 2,5,9 then start at edge N → `loadn`=0 only in cycle N+1, `running`=1 from N+2, buses 2/5/9. `timer_zero` held high through N+2 is ignored; `timer_zero` at N+5 → IDLE, buses 0.
- **Illegal key and zero start:** `key_digit`=12 → `err`, no shift. Then start with 0/0/0 → `err`, no load.
- **Cancel and reset:** `key_cancel` in RUN → IDLE, `running`=0 next cycle. `clr` during LOAD → `loadn`=1 after that edge and all outputs at reset values.
